// File: rtl/bmp_roi_copy.sv
// Region-of-interest copier: reads a window of a raw frame and writes it out as BMP pixel-array rows.
// Define BMP_ROI_PAD_EN to pad every destination row to a multiple of 4 bytes.
module bmp_roi_copy #(
  parameter int          WIDTH    = 100,
  parameter int          HEIGHT   = 100,
  parameter int          BPP      = 3,
  parameter int          RD_LAT   = 1,
  parameter logic [31:0] SRC_BASE = 32'd0,
  parameter logic [31:0] DST_BASE = 32'd54
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] x_min,
  input  logic [10:0] x_max,
  input  logic [10:0] y_min,
  input  logic [10:0] y_max,
  input  logic        bottom_up,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        done,
  output logic        err,
  output logic [31:0] byte_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_ROW_DRAIN = 3'd2;
  localparam logic [2:0] S_PAD       = 3'd3;
  localparam logic [2:0] S_FLUSH     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [31:0] WIDTH_W  = 32'(WIDTH);
  localparam logic [31:0] HEIGHT_W = 32'(HEIGHT);
  localparam logic [31:0] BPP_W    = 32'(BPP);

  logic [2:0]      state;
  logic [10:0]     xmn_q, ymn_q, ymx_q, y_q;
  logic            bu_q;
  logic [31:0]     row_bytes, col_cnt;
  logic [1:0]      pad_n, pad_left;
  logic [RD_LAT:1] tag_v;
  logic            reject, drain_busy, last_row, row_end;
  logic [10:0]     y_first, y_next;

  function automatic logic [31:0] row_addr(input logic [10:0] y, input logic [10:0] x);
    return SRC_BASE + ({21'd0, y} * WIDTH_W + {21'd0, x}) * BPP_W;
  endfunction

  assign reject = (x_min > x_max) || (y_min > y_max) ||
                  ({21'd0, x_max} >= WIDTH_W) || ({21'd0, y_max} >= HEIGHT_W);
  assign y_first  = bottom_up ? y_max : y_min;
  assign last_row = bu_q ? (y_q == ymn_q) : (y_q == ymx_q);
  assign y_next   = bu_q ? (y_q - 11'd1) : (y_q + 11'd1);

`ifdef BMP_ROI_PAD_EN
  assign pad_n = 2'd0 - row_bytes[1:0];
`else
  assign pad_n = 2'd0;
`endif

  // The drain ends once the only in-flight tag left is the one writing this cycle.
  // NOTE: combinational outputs get a default before the loop so no latch is inferred.
  always_comb begin
    drain_busy = 1'b0;
    for (int i = 1; i < RD_LAT; i++) drain_busy = drain_busy | tag_v[i];
  end

  assign row_end = (state == S_ROW_DRAIN && !drain_busy && pad_n == 2'd0) ||
                   (state == S_PAD && pad_left == 2'd0);

  assign rd_en   = (state == S_RUN);
  assign wr_en   = tag_v[RD_LAT] || (state == S_PAD);
  assign wr_data = tag_v[RD_LAT] ? rd_data : 8'h00;
  assign done    = (state == S_DONE);

  // Read tags: a write fires when a tag leaves the last stage, aligned with rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[1] <= rd_en;
      for (int i = 2; i <= RD_LAT; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  // NOTE: window, row and column registers are loaded on every accepted start,
  // so only control and visible outputs sit in the reset branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      err        <= 1'b0;
      rd_addr    <= 32'd0;
      wr_addr    <= DST_BASE;
      byte_count <= 32'd0;
    end else begin
      if (wr_en) begin
        wr_addr    <= wr_addr + 32'd1;
        byte_count <= byte_count + 32'd1;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (reject) begin
              state <= S_DONE;
              err   <= 1'b1;
            end else begin
              state      <= S_RUN;
              err        <= 1'b0;
              byte_count <= 32'd0;
              wr_addr    <= DST_BASE;
              xmn_q      <= x_min;
              ymn_q      <= y_min;
              ymx_q      <= y_max;
              bu_q       <= bottom_up;
              y_q        <= y_first;
              rd_addr    <= row_addr(y_first, x_min);
              col_cnt    <= 32'd0;
              row_bytes  <= ({21'd0, x_max} - {21'd0, x_min} + 32'd1) * BPP_W;
            end
          end
        end
        // Bytes of one row are contiguous in the source, so the address just counts up.
        S_RUN: begin
          if (col_cnt == row_bytes - 32'd1) begin
            state <= S_ROW_DRAIN;
          end else begin
            col_cnt <= col_cnt + 32'd1;
            rd_addr <= rd_addr + 32'd1;
          end
        end
        S_ROW_DRAIN: begin
          if (!drain_busy && pad_n != 2'd0) begin
            state    <= S_PAD;
            pad_left <= pad_n - 2'd1;
          end
        end
        S_PAD: begin
          if (pad_left != 2'd0) pad_left <= pad_left - 2'd1;
        end
        S_FLUSH: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
      if (row_end) begin
        if (last_row) begin
          state <= S_FLUSH;
        end else begin
          state   <= S_RUN;
          y_q     <= y_next;
          rd_addr <= row_addr(y_next, xmn_q);
          col_cnt <= 32'd0;
        end
      end
    end
  end

endmodule
